// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, memory FSM states and load/store decode for the M stage
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } dmem_state_e;

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_store_align.sv
// rtl/dmem_store_align.sv - byte enables, lane-replicated store data and alignment check
module dmem_store_align
  import mips_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned
);

  // Loads always fetch the full word; the extension stage picks the lane.
  always_comb begin
    o_be         = 4'b1111;
    o_wdata      = i_wdata;
    o_misaligned = 1'b0;
    case (i_op)
      OP_SB: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      OP_SH: begin
        o_be         = 4'b0011 << {i_off[1], 1'b0};
        o_wdata      = {2{i_wdata[15:0]}};
        o_misaligned = i_off[0];
      end
      OP_LH, OP_LHU: o_misaligned = i_off[0];
      OP_LW, OP_SW:  o_misaligned = |i_off;
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - M-stage load/store sequencer onto a handshaked data-memory port
module dmem_access_ctrl
  import mips_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en_i,
  input  logic [5:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic        bus_err_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic [5:0]  ld_op_o,
  output logic [1:0]  ld_off_o,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [3:0]  dm_be_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  input  logic        dm_ready_i,
  input  logic        dm_rvalid_i,
  input  logic [31:0] dm_rdata_i
);

  localparam int CNT_W = (BUS_TIMEOUT > 255) ? $clog2(BUS_TIMEOUT + 1) : 8;

  dmem_state_e      r_state;
  dmem_state_e      w_next;
  logic [5:0]       r_op;
  logic [1:0]       r_off;
  logic             r_discard;
  logic [CNT_W-1:0] r_cnt;

  logic        w_is_ld;
  logic        w_is_st;
  logic        w_is_mem;
  logic        w_misaligned;
  logic        w_start;
  logic        w_tmo_hit;
  logic        w_bus_err;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  assign w_is_ld  = is_load(op_i);
  assign w_is_st  = is_store(op_i);
  assign w_is_mem = w_is_ld | w_is_st;

  dmem_store_align u_align (
    .i_op         (op_i),
    .i_off        (addr_i[1:0]),
    .i_wdata      (wdata_i),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned)
  );

  assign w_start   = (r_state == ST_IDLE) && mem_en_i && w_is_mem && !w_misaligned && !flush_i;
  assign adel_o    = (r_state == ST_IDLE) && mem_en_i && w_is_ld && w_misaligned;
  assign ades_o    = (r_state == ST_IDLE) && mem_en_i && w_is_st && w_misaligned;
  assign w_tmo_hit = (BUS_TIMEOUT != 0) && (r_cnt == CNT_W'(BUS_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_bus_err = 1'b0;
    stall_o   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stall_o = w_start;
        if (w_start) w_next = ST_REQ;
      end
      ST_REQ: begin
        stall_o = 1'b1;
        // Acceptance beats a same-cycle flush: the load must still be drained.
        if (dm_ready_i) begin
          if (is_load(r_op)) w_next = ST_WAIT;
          else if (flush_i)  w_next = ST_IDLE;
          else               w_next = ST_DONE;
        end else if (flush_i) begin
          w_next = ST_IDLE;
        end else if (w_tmo_hit) begin
          w_next    = ST_IDLE;
          w_bus_err = 1'b1;
        end
      end
      ST_WAIT: begin
        // A discarded read only holds the pipe if a new access is waiting behind it.
        stall_o = !r_discard || (mem_en_i && w_is_mem);
        if (dm_rvalid_i) begin
          w_next = (r_discard || flush_i) ? ST_IDLE : ST_DONE;
        end else if (w_tmo_hit) begin
          w_next    = ST_IDLE;
          w_bus_err = !r_discard && !flush_i;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || (w_next != r_state) || !((r_state == ST_REQ) || (r_state == ST_WAIT))) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op          <= '0;
      r_off         <= '0;
      r_discard     <= 1'b0;
      dm_req_o      <= 1'b0;
      dm_we_o       <= 1'b0;
      dm_be_o       <= '0;
      dm_addr_o     <= '0;
      dm_wdata_o    <= '0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      ld_op_o       <= '0;
      ld_off_o      <= '0;
      bus_err_o     <= 1'b0;
    end else begin
      rdata_valid_o <= 1'b0;
      bus_err_o     <= w_bus_err;

      if (w_start) begin
        r_op       <= op_i;
        r_off      <= addr_i[1:0];
        dm_req_o   <= 1'b1;
        dm_we_o    <= w_is_st;
        dm_be_o    <= w_be;
        dm_addr_o  <= {addr_i[31:2], 2'b00};
        dm_wdata_o <= w_is_st ? w_wdata : '0;
      end

      if ((r_state == ST_REQ) && (w_next != ST_REQ)) dm_req_o <= 1'b0;

      if (w_next == ST_IDLE)                                      r_discard <= 1'b0;
      else if (flush_i && ((r_state == ST_WAIT) || (r_state == ST_REQ))) r_discard <= 1'b1;

      if ((r_state == ST_WAIT) && (w_next == ST_DONE)) begin
        rdata_o       <= dm_rdata_i;
        ld_op_o       <= r_op;
        ld_off_o      <= r_off;
        rdata_valid_o <= 1'b1;
      end
    end
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage controller that sequences every load/store of the MIPS pipeline onto a handshaked data-memory port. It checks alignment, generates word address, byte enables and lane-replicated store data, holds the pipeline with a stall until the access completes, and returns the raw read word with the registered opcode and byte offset to the downstream load-extension logic. It also raises address-error and bus-timeout exceptions.

## Interface
- `BUS_TIMEOUT`, default 255: maximum cycles spent in REQ or WAIT before a bus error is flagged. 0 disables the timeout.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_en_i` in 1: the M-stage instruction is valid and not killed.
- `op_i` in 6: instruction opcode, bits [31:26].
- `addr_i` in 32: effective byte address.
- `wdata_i` in 32: store data (rt).
- `flush_i` in 1: exception or redirect; cancels the pending access.
- `stall_o` out 1: freeze IF..M.
- `adel_o` / `ades_o` out 1: load / store address error, combinational.
- `bus_err_o` out 1: timeout pulse.
- `rdata_o` out 32: raw read word.
- `rdata_valid_o` out 1: one-cycle pulse.
- `ld_op_o` out 6: registered opcode of the completing load.
- `ld_off_o` out 2: registered addr[1:0] of the completing load.
- `dm_req_o` out 1: memory request.
- `dm_we_o` out 1: write enable.
- `dm_be_o` out 4: byte enables.
- `dm_addr_o` out 32: word address, bits [1:0] = 00.
- `dm_wdata_o` out 32: store data.
- `dm_ready_i` in 1: request accepted this cycle.
- `dm_rvalid_i` in 1: read data valid.
- `dm_rdata_i` in 32: read data.

## Operation
- Decoded ops:
  - LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101.
  - SB 101000, SH 101001, SW 101011.
  - Any other op is ignored: no stall, no request.
- Alignment:
  - Halfword ops require addr[0]=0.
  - Word ops require addr[1:0]=00.
  - A violation asserts adel_o (loads) or ades_o (stores) combinationally while in IDLE with mem_en_i=1.
  - A misaligned access issues no memory request and causes no stall.
- Byte enables:
  - SB: 0001 << addr[1:0].
  - SH: 0011 << {addr[1],1'b0}.
  - SW: 1111.
  - All loads: 1111.
- Store data: SB is {4{wdata[7:0]}}; SH is {2{wdata[15:0]}}; SW passes wdata unchanged.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on a valid, aligned op with flush_i=0, latch op, address, byte enables and store data, then go to REQ. stall_o=1 combinationally in that cycle.
  - REQ: dm_req_o=1; all dm_* outputs are stable until accepted. On dm_ready_i, a store goes to DONE and a load goes to WAIT.
  - WAIT: on dm_rvalid_i, capture dm_rdata_i into rdata_o and go to DONE.
  - DONE: stall_o=0. rdata_valid_o=1 for loads only. Return to IDLE. The pipeline advances, so the access is never re-issued.
- stall_o=1 in REQ and WAIT.
- Flush:
  - In IDLE: the access is not started.
  - In REQ before acceptance: drop dm_req_o next cycle, go to IDLE.
  - In WAIT: set a discard flag, drain until dm_rvalid_i, go to IDLE without rdata_valid_o.
  - In all three cases stall_o deasserts the cycle after flush.
- Timeout:
  - An 8+ bit counter runs in REQ/WAIT and clears on every state entry.
  - Reaching BUS_TIMEOUT pulses bus_err_o for one cycle and goes to IDLE with no data.
- Reset values: state IDLE, counter 0, discard 0. All outputs 0: dm_req_o, dm_we_o, dm_be_o, dm_addr_o, dm_wdata_o, rdata_o, rdata_valid_o, ld_op_o, ld_off_o, bus_err_o, stall_o.
- Reset mid-access: dm_req_o is low the cycle after rst; any later dm_rvalid_i is ignored in IDLE.

## Timing
- All dm_* outputs are registered.
- adel_o, ades_o and the IDLE-cycle stall_o are combinational.
- Best-case store (ready in first REQ cycle): 2 stall cycles (IDLE accept, REQ), then DONE.
- Best-case load (ready at first REQ, rvalid next cycle): 3 stall cycles (IDLE, REQ, WAIT), then DONE.
  - rdata_valid_o, rdata_o, ld_op_o and ld_off_o are valid in DONE.
- dm_rvalid_i in the same cycle as dm_ready_i is not legal; the memory returns data ≥1 cycle after acceptance.
- Simultaneous flush_i and dm_ready_i in REQ: the access is accepted. A store is lost (no DONE); a load takes the discard path.

## Structure
- Shared package `mips_pkg`:
  - opcode constants (OP_LB … OP_SW)
  - FSM state enum
  - an `is_load`/`is_store` decode function
- One sub-module `dmem_store_align`: combinational op + addr[1:0] + wdata → byte enables, replicated data, misaligned flag.
- FSM, timeout counter and response capture stay in the top level.

## Test plan
- SB addr 0x1003, wdata 0x000000AB, ready immediate → dm_be_o=1000, dm_wdata_o=0xABABABAB, dm_addr_o=0x1000, stall high 2 cycles.
- LH addr 0x2002, ready immediate, rvalid after 2 cycles with 0x8001_1234 → rdata_o=0x80011234, ld_op_o=100001, ld_off_o=10, rdata_valid_o one cycle, 4 stall cycles.
- LW addr 0x3001 → adel_o=1 the same cycle, no dm_req_o, stall_o=0. SH addr 0x3001 → ades_o=1.
- LW with flush_i asserted in WAIT, rvalid 3 cycles later → no rdata_valid_o, FSM returns to IDLE, next LW proceeds normally.
- BUS_TIMEOUT=4, dm_ready_i held low → bus_err_o pulses once after 4 REQ cycles, stall_o drops, dm_req_o low.
- rst asserted in WAIT → next cycle all outputs 0, FSM in IDLE; a late dm_rvalid_i produces no rdata_valid_o.
